// File: rtl/spi_pin_ctrl_pkg.sv
// Shared frame layout, opcodes and pulse-engine types for the SPI pin controller.
// Frame layout: [15:12] opcode, [11:8] reserved, [7:0] pin index.
package spi_pin_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int IDX_W   = 8;
  localparam int OP_W    = 4;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int IDX_MSB = 7;
  localparam int CNT_W   = 24;

  localparam logic [OP_W-1:0] OP_NOP     = 4'd0;
  localparam logic [OP_W-1:0] OP_SET     = 4'd1;
  localparam logic [OP_W-1:0] OP_CLR     = 4'd2;
  localparam logic [OP_W-1:0] OP_TOGGLE  = 4'd3;
  localparam logic [OP_W-1:0] OP_PULSE   = 4'd4;
  localparam logic [OP_W-1:0] OP_ALL_CLR = 4'd5;

  typedef enum logic [0:0] {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

  function automatic logic opcode_known(input logic [OP_W-1:0] op);
    return (op <= OP_ALL_CLR);
  endfunction

  // Opcodes whose index field addresses a single pin and must be range checked.
  function automatic logic opcode_indexed(input logic [OP_W-1:0] op);
    return (op >= OP_SET) && (op <= OP_PULSE);
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver oversampled in the clk domain.
// Emits a one-cycle strobe with opcode and index for every complete 16-bit frame.
module spi_frame_rx
  import spi_pin_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             frame_valid,
  output logic [OP_W-1:0]  frame_op,
  output logic [IDX_W-1:0] frame_idx
);

  localparam int                  BIT_CNT_W = $clog2(FRAME_W);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);

  logic [1:0]             sclk_sync_r;
  logic [1:0]             cs_sync_r;
  logic [1:0]             mosi_sync_r;
  logic                   sclk_prev_r;
  logic [FRAME_W-2:0]     shift_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic                   frame_valid_r;
  logic [OP_W-1:0]        frame_op_r;
  logic [IDX_W-1:0]       frame_idx_r;

  logic                   sclk_rise_s;
  logic                   cs_active_s;
  logic [FRAME_W-2:0]     shift_nxt_s;

  // Two-flop synchronisers plus a delayed sclk copy for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= 2'b00;
      cs_sync_r   <= 2'b11;
      mosi_sync_r <= 2'b00;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      cs_sync_r   <= {cs_sync_r[0], cs_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      sclk_prev_r <= sclk_sync_r[1];
    end
  end

  // Only 15 bits are stored: the 16th bit of a frame is taken live from mosi.
  always_comb begin
    sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
    cs_active_s = ~cs_sync_r[1];
    shift_nxt_s = {shift_r[FRAME_W-3:0], mosi_sync_r[1]};
  end

  // Shift register, bit counter and frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r       <= '0;
      bit_cnt_r     <= '0;
      frame_valid_r <= 1'b0;
      frame_op_r    <= OP_NOP;
      frame_idx_r   <= '0;
    end else begin
      frame_valid_r <= 1'b0;
      if (!cs_active_s) begin
        bit_cnt_r <= '0;
      end else if (sclk_rise_s) begin
        shift_r <= shift_nxt_s;
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_r     <= '0;
          frame_valid_r <= 1'b1;
          frame_op_r    <= shift_r[OP_MSB-1:OP_LSB-1];
          frame_idx_r   <= {shift_r[IDX_MSB-1:0], mosi_sync_r[1]};
        end else begin
          bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign frame_valid = frame_valid_r;
  assign frame_op    = frame_op_r;
  assign frame_idx   = frame_idx_r;

endmodule

// File: rtl/spi_pin_ctrl.sv
// SPI-commanded pin controller: decodes frames into SET/CLR/TOGGLE/PULSE/ALL_CLR
// on a registered pin vector, with a single-channel timed pulse engine.
module spi_pin_ctrl
  import spi_pin_ctrl_pkg::*;
#(
  parameter int NUM_PINS     = 64,
  parameter int PULSE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic [NUM_PINS-1:0] pins,
  output logic                cmd_done,
  output logic                cmd_err,
  output logic                pulse_busy
);

  localparam int               PIN_W        = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
  localparam logic [IDX_W:0]   NUM_PINS_W   = (IDX_W + 1)'(NUM_PINS);
  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_CYCLES - 1);

  logic                frame_valid_s;
  logic [OP_W-1:0]     op_s;
  logic [IDX_W-1:0]    idx_s;

  logic [NUM_PINS-1:0] pins_r;
  pulse_state_e        state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [PIN_W-1:0]    pidx_r;
  logic                done_r;
  logic                err_r;
  logic                busy_r;

  logic                idx_in_range_s;
  logic                frame_ok_s;
  logic                apply_s;
  logic                reject_s;
  logic [OP_W-1:0]     op_eff_s;
  logic [PIN_W-1:0]    pin_sel_s;
  logic                pulse_hit_s;
  logic [NUM_PINS-1:0] pins_nxt_s;
  pulse_state_e        state_nxt_s;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [PIN_W-1:0]    pidx_nxt_s;

  spi_frame_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .frame_valid (frame_valid_s),
    .frame_op    (op_s),
    .frame_idx   (idx_s)
  );

  // Frame validation; a rejected or absent frame decodes as NOP.
  always_comb begin
    idx_in_range_s = ({1'b0, idx_s} < NUM_PINS_W);
    frame_ok_s     = opcode_known(op_s) & (idx_in_range_s | ~opcode_indexed(op_s));
    apply_s        = frame_valid_s & frame_ok_s;
    reject_s       = frame_valid_s & ~frame_ok_s;
    op_eff_s       = apply_s ? op_s : OP_NOP;
    pin_sel_s      = idx_s[PIN_W-1:0];
    pulse_hit_s    = (state_r == PULSE_ACTIVE) && (pidx_r == pin_sel_s);
  end

  // Next pin/pulse state: timer expiry first, then the command overrides it.
  always_comb begin
    pins_nxt_s  = pins_r;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pidx_nxt_s  = pidx_r;

    if (state_r == PULSE_ACTIVE) begin
      if (cnt_r == '0) begin
        pins_nxt_s[pidx_r] = 1'b0;
        state_nxt_s        = PULSE_IDLE;
      end else begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end

    case (op_eff_s)
      OP_SET: begin
        pins_nxt_s[pin_sel_s] = 1'b1;
        state_nxt_s           = pulse_hit_s ? PULSE_IDLE : state_nxt_s;
      end
      OP_CLR: begin
        pins_nxt_s[pin_sel_s] = 1'b0;
        state_nxt_s           = pulse_hit_s ? PULSE_IDLE : state_nxt_s;
      end
      OP_TOGGLE: begin
        pins_nxt_s[pin_sel_s] = ~pins_r[pin_sel_s];
        state_nxt_s           = pulse_hit_s ? PULSE_IDLE : state_nxt_s;
      end
      OP_PULSE: begin
        // Release the previous pulse pin before driving the new one so a retrigger stays high.
        pins_nxt_s[pidx_r]    = (state_r == PULSE_ACTIVE) ? 1'b0 : pins_nxt_s[pidx_r];
        pins_nxt_s[pin_sel_s] = 1'b1;
        state_nxt_s           = PULSE_ACTIVE;
        cnt_nxt_s             = PULSE_RELOAD;
        pidx_nxt_s            = pin_sel_s;
      end
      OP_ALL_CLR: begin
        pins_nxt_s  = '0;
        state_nxt_s = PULSE_IDLE;
        cnt_nxt_s   = '0;
      end
      OP_NOP: begin
        pins_nxt_s = pins_nxt_s;
      end
      default: begin
        pins_nxt_s = pins_nxt_s;
      end
    endcase
  end

  // Pin register, pulse FSM state and status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pins_r  <= '0;
      state_r <= PULSE_IDLE;
      cnt_r   <= '0;
      pidx_r  <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pins_r  <= pins_nxt_s;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pidx_r  <= pidx_nxt_s;
      done_r  <= apply_s;
      err_r   <= reject_s;
      busy_r  <= (state_nxt_s == PULSE_ACTIVE);
    end
  end

  assign pins       = pins_r;
  assign cmd_done   = done_r;
  assign cmd_err    = err_r;
  assign pulse_busy = busy_r;

endmodule

// File: tb/tb_spi_pin_ctrl.sv
// Directed bench for spi_pin_ctrl: a frame table plus hand-written pulse, CS and reset sequences.
// A second instance with a long pulse lets commands arrive while a pulse is still running.
module tb_spi_pin_ctrl;

  localparam int NP = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic [NP-1:0] pins, pins_l;
  logic          cmd_done, cmd_err, pulse_busy;
  logic          cmd_done_l, cmd_err_l, pulse_busy_l;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_l_cnt = 0;
  int err_l_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] frame;
    logic [63:0] pins;
    int          done;
    int          err;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  spi_pin_ctrl #(.NUM_PINS(NP), .PULSE_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .pins(pins), .cmd_done(cmd_done), .cmd_err(cmd_err), .pulse_busy(pulse_busy)
  );

  spi_pin_ctrl #(.NUM_PINS(NP), .PULSE_CYCLES(1000)) dut_l (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .pins(pins_l), .cmd_done(cmd_done_l), .cmd_err(cmd_err_l), .pulse_busy(pulse_busy_l)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      done_cnt   <= done_cnt + (cmd_done ? 1 : 0);
      err_cnt    <= err_cnt + (cmd_err ? 1 : 0);
      done_l_cnt <= done_l_cnt + (cmd_done_l ? 1 : 0);
      err_l_cnt  <= err_l_cnt + (cmd_err_l ? 1 : 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      mosi = f[i];
      #40;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] f);
    cs_n = 1'b0;
    #40;
    shift_bits(f, 15, 0);
    #40;
    cs_n = 1'b1;
    #80;
  endtask

  initial begin
    int k, hi, bz, d0, e0, t7;
    logic prev3;

    vecs[0]  = '{16'h1005, 64'h0000_0000_0000_0020, 1, 0};
    vecs[1]  = '{16'h3005, 64'h0000_0000_0000_0000, 1, 0};
    vecs[2]  = '{16'h9000, 64'h0000_0000_0000_0000, 0, 1};
    vecs[3]  = '{16'h1040, 64'h0000_0000_0000_0000, 0, 1};
    vecs[4]  = '{16'h103F, 64'h8000_0000_0000_0000, 1, 0};
    vecs[5]  = '{16'h2F3F, 64'h0000_0000_0000_0000, 1, 0};
    vecs[6]  = '{16'h1000, 64'h0000_0000_0000_0001, 1, 0};
    vecs[7]  = '{16'h30FF, 64'h0000_0000_0000_0001, 0, 1};
    vecs[8]  = '{16'h0000, 64'h0000_0000_0000_0001, 1, 0};
    vecs[9]  = '{16'h100A, 64'h0000_0000_0000_0401, 1, 0};
    vecs[10] = '{16'h5123, 64'h0000_0000_0000_0000, 1, 0};
    vecs[11] = '{16'h6000, 64'h0000_0000_0000_0000, 0, 1};
    vecs[12] = '{16'hF001, 64'h0000_0000_0000_0000, 0, 1};
    vecs[13] = '{16'h40FF, 64'h0000_0000_0000_0000, 0, 1};

    // Reset state
    wait_clks(3);
    check("rst_pins", pins, 64'h0);
    check("rst_pins_l", pins_l, 64'h0);
    check("rst_done", 64'(cmd_done), 64'h0);
    check("rst_err", 64'(cmd_err), 64'h0);
    check("rst_busy", 64'(pulse_busy), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    wait_clks(2);

    // Frame table
    for (int i = 0; i < 14; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].frame);
      wait_clks(6);
      check($sformatf("vec%0d_pins", i), pins, vecs[i].pins);
      check($sformatf("vec%0d_done", i), 64'(done_cnt - d0), 64'(vecs[i].done));
      check($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'(vecs[i].err));
    end

    // PULSE 3 on the 10-cycle instance: measure high time and busy
    hi = 0;
    bz = 0;
    k = 0;
    fork
      send_frame(16'h4003);
      begin
        while (!pins[3] && k < 400) begin @(negedge clk); k++; end
        while (pins[3] && hi < 50) begin
          if (pulse_busy) bz++;
          hi++;
          @(negedge clk);
        end
      end
    join
    check("pulse_len", 64'(hi), 64'd10);
    check("pulse_busy_len", 64'(bz), 64'd10);
    check("pulse_end_busy", 64'(pulse_busy), 64'h0);
    check("pulse_end_pins", pins, 64'h0);

    // Long instance: PULSE 3, then PULSE 7 mid-pulse
    send_frame(16'h5000);
    wait_clks(6);
    send_frame(16'h4003);
    wait_clks(6);
    check("l_pulse3", pins_l, 64'h8);
    check("l_pulse3_busy", 64'(pulse_busy_l), 64'h1);
    k = 0;
    prev3 = 1'b0;
    fork
      send_frame(16'h4007);
      begin
        while (!pins_l[7] && k < 400) begin prev3 = pins_l[3]; @(negedge clk); k++; end
      end
    join_any
    t7 = cyc;
    wait fork;
    check("l_switch_prev3", 64'(prev3), 64'h1);
    check("l_switch_pins", pins_l, 64'h80);

    // Retrigger PULSE 7, then CLR 7 after the original expiry point
    d0 = done_l_cnt;
    k = 0;
    fork
      send_frame(16'h4007);
      begin
        while (done_l_cnt == d0 && k < 400) begin @(negedge clk); k++; end
      end
    join
    check("l_retrig_done", 64'(done_l_cnt - d0), 64'h1);
    cs_n = 1'b0;
    #40;
    shift_bits(16'h2007, 15, 1);
    while (cyc < t7 + 1003) @(negedge clk);
    check("l_retrig_extend", pins_l, 64'h80);
    check("l_retrig_busy", 64'(pulse_busy_l), 64'h1);
    shift_bits(16'h2007, 0, 0);
    #40;
    cs_n = 1'b1;
    wait_clks(8);
    check("l_clr_mid_pulse", pins_l, 64'h0);
    check("l_clr_busy", 64'(pulse_busy_l), 64'h0);

    // SET on another pin leaves the pulse running; SET on the pulsing pin cancels it
    send_frame(16'h4008);
    wait_clks(4);
    check("l_pulse8", pins_l, 64'h100);
    send_frame(16'h1009);
    wait_clks(4);
    check("l_set_other", pins_l, 64'h300);
    check("l_set_other_busy", 64'(pulse_busy_l), 64'h1);
    send_frame(16'h1008);
    wait_clks(4);
    check("l_set_hit_busy", 64'(pulse_busy_l), 64'h0);
    wait_clks(1050);
    check("l_no_autoclear", pins_l, 64'h300);

    // Partial frame dropped by cs_n, then two frames in one CS
    send_frame(16'h5000);
    wait_clks(6);
    d0 = done_cnt;
    e0 = err_cnt;
    cs_n = 1'b0;
    #40;
    shift_bits(16'h1001, 15, 7);
    #40;
    cs_n = 1'b1;
    #200;
    cs_n = 1'b0;
    #40;
    shift_bits(16'h1001, 15, 0);
    shift_bits(16'h1002, 15, 0);
    #40;
    cs_n = 1'b1;
    #80;
    wait_clks(6);
    check("cs_pins", pins, 64'h6);
    check("cs_pins_l", pins_l, 64'h6);
    check("cs_done", 64'(done_cnt - d0), 64'h2);
    check("cs_err", 64'(err_cnt - e0), 64'h0);

    // Reset mid-pulse and mid-frame
    send_frame(16'h4009);
    wait_clks(2);
    check("pre_rst_busy_l", 64'(pulse_busy_l), 64'h1);
    cs_n = 1'b0;
    #40;
    shift_bits(16'h1004, 15, 7);
    #3;
    rst_n = 1'b0;
    #2;
    check("mid_rst_pins", pins, 64'h0);
    check("mid_rst_pins_l", pins_l, 64'h0);
    check("mid_rst_busy_l", 64'(pulse_busy_l), 64'h0);
    cs_n = 1'b1;
    #100;
    @(negedge clk) rst_n = 1'b1;
    wait_clks(2);
    d0 = done_cnt;
    send_frame(16'h1004);
    wait_clks(6);
    check("post_rst_pins", pins, 64'h10);
    check("post_rst_pins_l", pins_l, 64'h10);
    check("post_rst_done", 64'(done_cnt - d0), 64'h1);
    check("total_err_l", 64'(err_l_cnt), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
